operand_fetch: RTL

- Read-side front end of the 8-bit, 4-entry register file (two combinational read ports, one clocked write port).
- Accepts issue requests and drives the file's read addresses.
- Resolves read-after-write and write-after-write hazards with a per-register busy scoreboard, bypassing same-cycle writeback data.
- Presents the fetched operand pair to the execute stage over a valid/ready handshake.

---
 rtl/operand_fetch_pkg.sv | 14 +
 rtl/operand_fetch_if.sv | 24 ++
 rtl/operand_fetch_scoreboard.sv | 30 +++
 rtl/operand_fetch.sv | 55 +++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: register file widths, address/data types and the operand bundle.
package regfile_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int REG_COUNT = 4;
   localparam int ADDR_WIDTH = $clog2(REG_COUNT);
   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef struct packed {
      data_t a;
      data_t b;
      reg_addr_t dest;
      logic writes_dest;
   } operand_bundle_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: issue, register-file read, writeback and execute-side signals.
interface operand_fetch_if;
   import regfile_pkg::*;
   logic issue_valid, issue_ready, issue_writes_dest;
   reg_addr_t issue_a_addr, issue_b_addr, issue_dest_addr;
   reg_addr_t rf_a_addr, rf_b_addr;
   data_t rf_a_data, rf_b_data;
   logic wb_valid;
   reg_addr_t wb_addr;
   data_t wb_data;
   logic op_valid, op_ready, op_writes_dest;
   data_t op_a, op_b;
   reg_addr_t op_dest_addr;
   modport master (
      output issue_valid, issue_a_addr, issue_b_addr, issue_dest_addr, issue_writes_dest,
      output rf_a_data, rf_b_data, wb_valid, wb_addr, wb_data, op_ready,
      input issue_ready, rf_a_addr, rf_b_addr, op_valid, op_a, op_b, op_dest_addr, op_writes_dest
   );
   modport slave (
      input issue_valid, issue_a_addr, issue_b_addr, issue_dest_addr, issue_writes_dest,
      input rf_a_data, rf_b_data, wb_valid, wb_addr, wb_data, op_ready,
      output issue_ready, rf_a_addr, rf_b_addr, op_valid, op_a, op_b, op_dest_addr, op_writes_dest
   );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard: per-register busy bits; availability includes this cycle's writeback.
module operand_fetch_scoreboard
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic set_en,
   input  reg_addr_t set_addr,
   input  logic clr_en,
   input  reg_addr_t clr_addr,
   input  reg_addr_t a_addr,
   input  reg_addr_t b_addr,
   input  reg_addr_t d_addr,
   output logic a_avail,
   output logic b_avail,
   output logic d_avail
);
   logic [REG_COUNT-1:0] busy, busy_next;
   always_comb begin
      busy_next = busy;
      if (clr_en) busy_next[clr_addr] = 1'b0;
      // a new writer issued alongside the old writer's writeback stays pending
      if (set_en) busy_next[set_addr] = 1'b1;
   end
   always_ff @(posedge clk)
      busy <= reset ? '0 : busy_next;
   assign a_avail = !busy[a_addr] || (clr_en && clr_addr == a_addr);
   assign b_avail = !busy[b_addr] || (clr_en && clr_addr == b_addr);
   assign d_avail = !busy[d_addr] || (clr_en && clr_addr == d_addr);
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: hazard-checked operand read with writeback bypass and a one-entry output register.
module operand_fetch
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic reset,
   operand_fetch_if.slave bus,
   output logic [7:0] stall_count
);
   logic a_avail, b_avail, d_avail, hazard, accept, valid_q;
   operand_bundle_t op_q;
   operand_fetch_scoreboard u_sb (
      .clk(clk),
      .reset(reset),
      .set_en(accept && bus.issue_writes_dest),
      .set_addr(bus.issue_dest_addr),
      .clr_en(bus.wb_valid),
      .clr_addr(bus.wb_addr),
      .a_addr(bus.issue_a_addr),
      .b_addr(bus.issue_b_addr),
      .d_addr(bus.issue_dest_addr),
      .a_avail(a_avail),
      .b_avail(b_avail),
      .d_avail(d_avail)
   );
   assign bus.rf_a_addr = bus.issue_a_addr;
   assign bus.rf_b_addr = bus.issue_b_addr;
   assign hazard = !a_avail || !b_avail || (bus.issue_writes_dest && !d_avail);
   assign bus.issue_ready = (!valid_q || bus.op_ready) && !hazard;
   assign accept = bus.issue_valid && bus.issue_ready;
   assign bus.op_valid = valid_q;
   assign bus.op_a = op_q.a;
   assign bus.op_b = op_q.b;
   assign bus.op_dest_addr = op_q.dest;
   assign bus.op_writes_dest = op_q.writes_dest;
   // the file only updates at the edge, so a same-cycle writeback must be forwarded
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         op_q <= '0;
         stall_count <= '0;
      end else begin
         if (accept) begin
            valid_q <= 1'b1;
            op_q.a <= (bus.wb_valid && bus.wb_addr == bus.issue_a_addr) ? bus.wb_data : bus.rf_a_data;
            op_q.b <= (bus.wb_valid && bus.wb_addr == bus.issue_b_addr) ? bus.wb_data : bus.rf_b_data;
            op_q.dest <= bus.issue_dest_addr;
            op_q.writes_dest <= bus.issue_writes_dest;
         end else if (bus.op_ready) begin
            valid_q <= 1'b0;
         end
         if (bus.issue_valid && hazard && stall_count != 8'hff) stall_count <= stall_count + 8'd1;
      end
   end
endmodule
